// File: rtl/gray_threshold_pkg.sv
// gray_threshold_pkg
//   Shared definitions for the gray threshold stage: frame-tracking state
//   encoding, binarized pixel words, default image geometry, skid-buffer
//   payload width and the pixel binarization helper.
package gray_threshold_pkg;

  localparam int DEF_IMG_WIDTH  = 640;
  localparam int DEF_IMG_HEIGHT = 480;

  localparam logic [31:0] PIX_ON  = 32'h00FF_FFFF;
  localparam logic [31:0] PIX_OFF = 32'h0000_0000;

  // Payload carried through the skid buffer: {TDATA, TUSER, TLAST}.
  localparam int PAYLOAD_W = 34;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // Unsigned 8-bit compare; a pixel equal to the threshold counts as "on".
  function automatic logic [31:0] binarize(input logic [7:0] gray, input logic [7:0] thr);
    logic [31:0] pix;
    if (gray >= thr) begin
      pix = PIX_ON;
    end else begin
      pix = PIX_OFF;
    end
    return pix;
  endfunction

endpackage

// File: rtl/gray_threshold_stage_if.sv
// gray_threshold_stage_if
//   AXI4-Stream style video beat bundle.
//   TVALID/TREADY : handshake, transfer when both high
//   TDATA[31:0]   : pixel word (gray value in [7:0] on the input side)
//   TUSER         : start of frame
//   TLAST         : end of line
//   modport master drives the beat, modport slave drives TREADY.
interface gray_threshold_stage_if;
  logic        TVALID;
  logic        TREADY;
  logic [31:0] TDATA;
  logic        TUSER;
  logic        TLAST;

  modport master (output TVALID, output TDATA, output TUSER, output TLAST, input TREADY);
  modport slave  (input TVALID, input TDATA, input TUSER, input TLAST, output TREADY);
endinterface

// File: rtl/axis_skid_buf.sv
// axis_skid_buf
//   Two-entry skid buffer with fully registered outputs.
//   clk, rst_n         : clock, synchronous active-low reset
//   s_valid/s_ready    : write side; s_ready is a register (= not full)
//   s_data             : write payload
//   m_valid/m_ready    : read side; m_valid is a register
//   m_data             : head-of-buffer payload (register)
//   s_ready does not depend combinationally on m_ready, so upstream
//   backpressure timing is isolated from downstream.
module axis_skid_buf #(
  parameter int DATA_W = 34
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data
);

  logic [1:0]        count_r;
  logic [1:0]        count_next_s;
  logic [DATA_W-1:0] head_r;
  logic [DATA_W-1:0] spare_r;
  logic              s_ready_r;
  logic              m_valid_r;
  logic              push_s;
  logic              pop_s;

  // Handshake decode and next occupancy.
  always_comb begin
    push_s = s_valid & s_ready_r;
    pop_s  = m_valid_r & m_ready;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + 2'd1;
      2'b01:   count_next_s = count_r - 2'd1;
      default: count_next_s = count_r;
    endcase
  end

  // Storage update; head_r always holds the oldest beat, spare_r the second.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r   <= 2'd0;
      head_r    <= {DATA_W{1'b0}};
      spare_r   <= {DATA_W{1'b0}};
      s_ready_r <= 1'b0;
      m_valid_r <= 1'b0;
    end else begin
      count_r   <= count_next_s;
      s_ready_r <= (count_next_s != 2'd2);
      m_valid_r <= (count_next_s != 2'd0);
      case (count_r)
        2'd0: begin
          if (push_s) head_r <= s_data;
        end
        2'd1: begin
          if (push_s && pop_s) begin
            head_r <= s_data;
          end else if (push_s) begin
            spare_r <= s_data;
          end
        end
        2'd2: begin
          if (pop_s) head_r <= spare_r;
        end
        default: begin
          head_r <= head_r;
        end
      endcase
    end
  end

  assign s_ready = s_ready_r;
  assign m_valid = m_valid_r;
  assign m_data  = head_r;

endmodule

// File: rtl/gray_threshold_stage.sv
// gray_threshold_stage
//   Binarizes an 8-bit gray video stream against a per-frame threshold and
//   checks line/frame structure.
//   aclk, aresetn   : clock, synchronous active-low reset
//   threshold[7:0]  : binarization threshold, captured on each accepted SOF
//   INPUT_STREAM    : slave beat port (gray in TDATA[7:0], SOF in TUSER, EOL in TLAST)
//   OUTPUT_STREAM   : master beat port (PIX_ON/PIX_OFF word, SOF, EOL), 1-cycle latency
//   frame_done      : 1-cycle pulse after the last beat of a frame is accepted
//   line_err        : 1-cycle pulse on a line-length or frame-structure violation
//   above_count     : on-pixel count of the last completed frame
//   Optional build macro GRAY_THRESHOLD_STATS_EN enables the on-pixel counter;
//   without it above_count is tied to zero.
module gray_threshold_stage
  import gray_threshold_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [7:0]                    threshold,
  gray_threshold_stage_if.slave         INPUT_STREAM,
  gray_threshold_stage_if.master        OUTPUT_STREAM,
  output logic                          frame_done,
  output logic                          line_err,
  output logic [31:0]                   above_count
);

  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  state_e                 state_r;
  logic [COL_W-1:0]       col_r;
  logic [ROW_W-1:0]       row_r;
  logic [7:0]             thr_q_r;
  logic                   frame_done_r;
  logic                   line_err_r;

  logic                   in_ready_s;
  logic                   accept_s;
  logic                   push_s;
  logic                   sof_s;
  logic                   eol_s;
  logic [7:0]             gray_s;
  logic [7:0]             thr_eff_s;
  logic [COL_W-1:0]       col_eff_s;
  logic [ROW_W-1:0]       row_eff_s;
  logic [PAYLOAD_W-1:0]   payload_s;
  logic [PAYLOAD_W-1:0]   out_payload_s;
  logic                   out_valid_s;
  logic                   unused_tdata_s;

  assign unused_tdata_s = ^INPUT_STREAM.TDATA[31:8];

  // Beat decode. An SOF beat is judged against the live threshold and at
  // position (0,0), so a restart takes effect on the SOF pixel itself.
  always_comb begin
    sof_s    = INPUT_STREAM.TUSER;
    eol_s    = INPUT_STREAM.TLAST;
    gray_s   = INPUT_STREAM.TDATA[7:0];
    accept_s = INPUT_STREAM.TVALID & in_ready_s;
    if (sof_s) begin
      thr_eff_s = threshold;
      col_eff_s = {COL_W{1'b0}};
      row_eff_s = {ROW_W{1'b0}};
    end else begin
      thr_eff_s = thr_q_r;
      col_eff_s = col_r;
      row_eff_s = row_r;
    end
    // In IDLE only an SOF beat produces output; other beats are swallowed.
    if (accept_s && (sof_s || (state_r == ACTIVE))) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    payload_s = {binarize(gray_s, thr_eff_s), sof_s, eol_s};
  end

  // Frame tracking FSM: position counters, threshold capture, status pulses.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r      <= IDLE;
      col_r        <= {COL_W{1'b0}};
      row_r        <= {ROW_W{1'b0}};
      thr_q_r      <= 8'h00;
      frame_done_r <= 1'b0;
      line_err_r   <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      line_err_r   <= 1'b0;
      if (push_s) begin
        if (sof_s) begin
          thr_q_r <= threshold;
          state_r <= ACTIVE;
          // SOF arriving anywhere but the frame origin is a structure error.
          if ((state_r == ACTIVE) && ((col_r != {COL_W{1'b0}}) || (row_r != {ROW_W{1'b0}}))) begin
            line_err_r <= 1'b1;
          end
        end
        if (eol_s) begin
          col_r <= {COL_W{1'b0}};
          if (col_eff_s != COL_LAST) begin
            line_err_r <= 1'b1;
          end
          if (row_eff_s == ROW_LAST) begin
            frame_done_r <= 1'b1;
            state_r      <= IDLE;
            row_r        <= {ROW_W{1'b0}};
          end else begin
            row_r <= row_eff_s + ROW_W'(1);
          end
        end else if (col_eff_s == COL_LAST) begin
          // Line ran to full width without EOL: flag and resynchronize.
          line_err_r <= 1'b1;
          col_r      <= {COL_W{1'b0}};
          row_r      <= row_eff_s;
        end else begin
          col_r <= col_eff_s + COL_W'(1);
          row_r <= row_eff_s;
        end
      end
    end
  end

`ifdef GRAY_THRESHOLD_STATS_EN
  logic [31:0] above_acc_r;
  logic [31:0] above_next_s;
  logic [31:0] above_count_r;

  // Running on-pixel count for the frame in progress, restarted by SOF.
  always_comb begin
    if (push_s && sof_s) begin
      above_next_s = {31'd0, (gray_s >= thr_eff_s)};
    end else if (push_s) begin
      above_next_s = above_acc_r + {31'd0, (gray_s >= thr_eff_s)};
    end else begin
      above_next_s = above_acc_r;
    end
  end

  // Accumulator and its snapshot, published together with frame_done.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      above_acc_r   <= 32'd0;
      above_count_r <= 32'd0;
    end else begin
      above_acc_r <= above_next_s;
      if (push_s && eol_s && (row_eff_s == ROW_LAST)) begin
        above_count_r <= above_next_s;
      end
    end
  end

  assign above_count = above_count_r;
`else
  assign above_count = 32'd0;
`endif

  axis_skid_buf #(
    .DATA_W (PAYLOAD_W)
  ) u_skid (
    .clk     (aclk),
    .rst_n   (aresetn),
    .s_valid (push_s),
    .s_ready (in_ready_s),
    .s_data  (payload_s),
    .m_valid (out_valid_s),
    .m_ready (OUTPUT_STREAM.TREADY),
    .m_data  (out_payload_s)
  );

  assign INPUT_STREAM.TREADY  = in_ready_s;
  assign OUTPUT_STREAM.TVALID = out_valid_s;
  assign OUTPUT_STREAM.TDATA  = out_payload_s[33:2];
  assign OUTPUT_STREAM.TUSER  = out_payload_s[1];
  assign OUTPUT_STREAM.TLAST  = out_payload_s[0];
  assign frame_done           = frame_done_r;
  assign line_err             = line_err_r;

endmodule

// File: doc/gray_threshold_stage.md
GRAY_THRESHOLD_STAGE -- requirements
Module: gray_threshold_stage

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640, meaning pixels per line.
REQ-002 SHALL have parameter IMG_HEIGHT, default 480, meaning lines per frame.
REQ-003 SHALL have port aclk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port aresetn, input, 1, a synchronous active-low reset.
REQ-005 SHALL have port threshold, input, 8, the binarization threshold, sampled at start of frame.
REQ-006 SHALL have port INPUT_STREAM_TVALID, input, 1, meaning upstream beat valid.
REQ-007 SHALL have port INPUT_STREAM_TREADY, output, 1, meaning this stage accepts a beat.
REQ-008 SHALL have port INPUT_STREAM_TDATA, input, 32, whose bits [7:0] carry the gray pixel; bits [31:8] are ignored.
REQ-009 SHALL have port INPUT_STREAM_TUSER, input, 1, meaning start of frame (SOF).
REQ-010 SHALL have port INPUT_STREAM_TLAST, input, 1, meaning end of line (EOL).
REQ-011 SHALL have port OUTPUT_STREAM_TVALID, output, 1, meaning output beat valid.
REQ-012 SHALL have port OUTPUT_STREAM_TREADY, input, 1, meaning downstream accepts.
REQ-013 SHALL have port OUTPUT_STREAM_TDATA, output, 32, carrying the binarized pixel.
REQ-014 SHALL have port OUTPUT_STREAM_TUSER, output, 1, carrying the forwarded SOF.
REQ-015 SHALL have port OUTPUT_STREAM_TLAST, output, 1, carrying the forwarded EOL.
REQ-016 SHALL have port frame_done, output, 1, a one-cycle pulse on acceptance of the last beat of a frame.
REQ-017 SHALL have port line_err, output, 1, a one-cycle pulse on a line length or frame structure violation.
REQ-018 SHALL have port above_count, output, 32, the count of pixels at or above threshold in the last completed frame.

Function
REQ-019 SHALL transfer a beat only when TVALID and TREADY are both high in the same cycle, on each side independently.
REQ-020 SHALL produce OUTPUT_STREAM_TDATA = 32'h00FFFFFF when gray >= thr_q, and 32'h00000000 otherwise, using an unsigned 8-bit compare.
REQ-021 SHALL forward TUSER and TLAST unchanged and aligned with their pixel.
REQ-022 SHALL use registered outputs with a 2-entry skid buffer: 1-cycle latency, 1 beat/cycle sustained, INPUT_STREAM_TREADY = buffer not full (registered).
REQ-023 SHALL have no combinational path from OUTPUT_STREAM_TREADY to INPUT_STREAM_TREADY.
REQ-024 SHALL implement states IDLE and ACTIVE: IDLE accepts beats, drops those without SOF (produces no output), and enters ACTIVE on an accepted SOF beat; ACTIVE processes all beats.
REQ-025 SHALL latch thr_q from threshold on every accepted SOF beat; thr_q is then used for that beat and the rest of the frame.
REQ-026 SHALL track col (width clog2(IMG_WIDTH)) and row (width clog2(IMG_HEIGHT)): col increments per accepted beat and clears on EOL; row increments on EOL.
REQ-027 SHALL pulse line_err and clear col when EOL arrives with col != IMG_WIDTH-1, or when col reaches IMG_WIDTH-1 without EOL.
REQ-028 SHALL pulse line_err and restart counting with col=0, row=0 and the new thr_q when SOF arrives in ACTIVE at col!=0 or row!=0.
REQ-029 SHALL, on EOL with row == IMG_HEIGHT-1, pulse frame_done and return to IDLE; a simultaneous line_err is also pulsed if the line was short.
REQ-030 SHALL have no wrap-around of col or row beyond the frame limits; the violations above always resynchronize the counters.

Reset
REQ-031 SHALL, while aresetn=0 at a rising edge, reset to: state IDLE, col=row=0, thr_q=0, skid buffer empty, INPUT_STREAM_TREADY=0 during reset and 1 the cycle after, OUTPUT_STREAM_TVALID=0, TDATA/TUSER/TLAST=0, frame_done=0, line_err=0, above_count=0.
REQ-032 SHALL discard buffered beats on reset mid-frame and restart in IDLE, waiting for the next SOF.

Configuration
REQ-033 SHALL, with GRAY_THRESHOLD_STATS_EN defined, count accepted pixels where gray >= thr_q in a 32-bit counter (cleared at SOF) and copy it to above_count in the cycle frame_done pulses.
REQ-034 SHALL, without GRAY_THRESHOLD_STATS_EN defined, drive above_count constant 0 and include no counter logic.

Structure
REQ-035 SHALL place the state enum (IDLE, ACTIVE), PIX_ON=32'h00FFFFFF, PIX_OFF=32'h0 and the default IMG_WIDTH/IMG_HEIGHT in package gray_threshold_pkg.
REQ-036 SHALL implement the 2-entry skid buffer as sub-module axis_skid_buf, with a 34-bit payload (TDATA, TUSER, TLAST).

Verification
REQ-037 SHALL cover: IMG_WIDTH=4, IMG_HEIGHT=2, threshold=8'h80, gray values 7F,80,FF,00 per line -> TDATA 0,00FFFFFF,00FFFFFF,0; frame_done pulses once; above_count=4 (STATS_EN).
REQ-038 SHALL cover: OUTPUT_STREAM_TREADY toggling 1/0 every cycle with continuous input -> no beat lost or duplicated, order preserved, INPUT_STREAM_TREADY drops only when 2 beats are buffered.
REQ-039 SHALL cover: EOL after 3 beats (width 4) -> line_err pulses 1 cycle, next line counted from col=0.
REQ-040 SHALL cover: threshold changed from 80 to 10 mid-frame -> current frame still uses 80; next SOF uses 10.
REQ-041 SHALL cover: 3 beats without SOF after reset -> no output beats; a SOF mid-frame -> line_err and frame restart.
REQ-042 SHALL cover: aresetn low for 1 cycle with 2 beats buffered -> OUTPUT_STREAM_TVALID=0 next cycle and above_count=0.
